// File: rtl/dmi_crc_check.sv
// Receive-side Ethernet FCS checker: CRC-32 over 16-bit frame words including the FCS,
// compared against the 802.3 residue. Define DMI_CRC_STATS_EN to build the frame/error counters.
module dmi_crc_check #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic             i_eof,
  input  logic             i_odd,
  input  logic [15:0]      i_data,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic             o_crc_err,
  output logic             o_len_err,
  output logic [CNT_W-1:0] o_frame_len,
  output logic [31:0]      o_crc,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_frame_cnt
);

  localparam logic [31:0]      CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0]      CRC_SEED    = 32'hFFFFFFFF;
  localparam logic [31:0]      CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [CNT_W-1:0] MIN_LEN     = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] MAX_LEN     = CNT_W'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Register holds x^31 in bit 31; each byte enters bit 0 first, as on the wire.
  function automatic logic [31:0] crc_step8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  // i_data[15:8] is the earlier byte, so it goes through the step first.
  function automatic logic [31:0] crc_step16(input logic [31:0] crc, input logic [15:0] data);
    return crc_step8(crc_step8(crc, data[15:8]), data[7:0]);
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      crc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             take_word;
  logic             start_frame;
  logic             odd_word;
  logic [31:0]      crc_base;
  logic [31:0]      crc_next;
  logic [CNT_W-1:0] cnt_base;
  logic [1:0]       word_bytes;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  logic             frame_end;
  logic             crc_match;
  logic             len_bad;

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    take_word   = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (i_valid && i_sof) begin
          take_word   = 1'b1;
          start_frame = 1'b1;
          state_d     = i_eof ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_valid) begin
          // A SOF here drops the frame in flight and restarts on this word.
          take_word   = 1'b1;
          start_frame = i_sof;
          state_d     = i_eof ? ST_DONE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    odd_word   = i_eof && i_odd;
    crc_base   = start_frame ? CRC_SEED : crc_q;
    crc_next   = odd_word ? crc_step8(crc_base, i_data[15:8]) : crc_step16(crc_base, i_data);
    cnt_base   = start_frame ? '0 : cnt_q;
    word_bytes = odd_word ? 2'd1 : 2'd2;
    cnt_sum    = {1'b0, cnt_base} + (CNT_W + 1)'(word_bytes);
    cnt_next   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  assign frame_end = (state_q == ST_DONE);
  assign crc_match = (crc_q == CRC_RESIDUE);
  assign len_bad   = (cnt_q < MIN_LEN) || (cnt_q > MAX_LEN);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC_SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take_word) begin
        crc_q <= crc_next;
        cnt_q <= cnt_next;
      end
    end
  end

  // Results are taken from the DONE cycle's registers, so a frame starting in DONE cannot disturb them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done      <= 1'b0;
      o_crc_ok    <= 1'b0;
      o_crc_err   <= 1'b0;
      o_len_err   <= 1'b0;
      o_frame_len <= '0;
    end else begin
      o_done <= frame_end;
      if (frame_end) begin
        o_crc_ok    <= crc_match;
        o_crc_err   <= !crc_match;
        o_len_err   <= len_bad;
        o_frame_len <= cnt_q;
      end
    end
  end

  assign o_crc = crc_q;

`ifdef DMI_CRC_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  // Counters move on the same edge as o_done, so they already include the frame being reported.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (frame_end) begin
      if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (!crc_match && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`else
  assign o_frame_cnt = '0;
  assign o_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmi_crc_check.sv
// Scoreboard bench for dmi_crc_check: a byte-level reflected CRC-32 reference predicts each
// frame's result, and a monitor compares whenever o_done pulses.
module tb_dmi_crc_check;

  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             i_sof;
  logic             i_eof;
  logic             i_odd;
  logic [15:0]      i_data;
  logic             o_done;
  logic             o_crc_ok;
  logic             o_crc_err;
  logic             o_len_err;
  logic [CNT_W-1:0] o_frame_len;
  logic [31:0]      o_crc;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_frame_cnt;

  dmi_crc_check #(
    .MIN_FRAME_BYTES(64),
    .MAX_FRAME_BYTES(1522),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .i_sof(i_sof),
    .i_eof(i_eof),
    .i_odd(i_odd),
    .i_data(i_data),
    .o_done(o_done),
    .o_crc_ok(o_crc_ok),
    .o_crc_err(o_crc_err),
    .o_len_err(o_len_err),
    .o_frame_len(o_frame_len),
    .o_crc(o_crc),
    .o_err_cnt(o_err_cnt),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef logic [7:0] bytes_t[$];

  typedef struct {
    bit          ok;
    bit          len_err;
    int          len;
    logic [31:0] crc;
    bit          chk_crc;
    int          frame_cnt;
    int          err_cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   m_frames = 0;
  int   m_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Classic LSB-first Ethernet CRC over a byte list, seed all-ones, no final inversion.
  function automatic logic [31:0] crc_reflected(input bytes_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Random payload followed by the transmitter's FCS (inverted CRC, low byte first).
  function automatic bytes_t make_frame(input int n_payload);
    bytes_t      f;
    logic [31:0] fcs;
    for (int i = 0; i < n_payload; i++) f.push_back(8'($urandom));
    fcs = ~crc_reflected(f);
    f.push_back(fcs[7:0]);
    f.push_back(fcs[15:8]);
    f.push_back(fcs[23:16]);
    f.push_back(fcs[31:24]);
    return f;
  endfunction

  function automatic void predict(input bytes_t f, input bit chk_crc);
    exp_t e;
    e.crc     = bitrev32(crc_reflected(f));
    e.ok      = (e.crc == 32'hC704DD7B);
    e.len     = (f.size() > 65535) ? 65535 : f.size();
    e.len_err = (e.len < 64) || (e.len > 1522);
    e.chk_crc = chk_crc;
    if (m_frames < 65535) m_frames++;
    if (!e.ok && m_errs < 65535) m_errs++;
`ifdef DMI_CRC_STATS_EN
    e.frame_cnt = m_frames;
    e.err_cnt   = m_errs;
`else
    e.frame_cnt = 0;
    e.err_cnt   = 0;
`endif
    sb.push_back(e);
  endfunction

  task automatic drive_word(input logic [15:0] d, input bit sof, input bit eof, input bit odd);
    i_valid = 1'b1;
    i_sof   = sof;
    i_eof   = eof;
    i_odd   = odd;
    i_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  // Gap cycles carry either invalid words or valid words without SOF, both to be ignored.
  task automatic gap(input int n);
    repeat (n) begin
      i_valid = 1'($urandom_range(0, 1));
      i_sof   = i_valid ? 1'b0 : 1'($urandom);
      i_eof   = 1'($urandom);
      i_odd   = 1'($urandom);
      i_data  = 16'($urandom);
      @(posedge i_clk);
      #1;
    end
  endtask

  // Drives the first n_words words of f; a complete frame ends with EOF and gets a prediction.
  task automatic send_words(input bytes_t f, input int n_words, input bit complete, input bit chk_crc);
    int          nw;
    bit          last;
    bit          odd;
    logic [7:0]  lo;
    nw = (f.size() + 1) / 2;
    if (complete) predict(f, chk_crc);
    for (int w = 0; w < n_words && w < nw; w++) begin
      last = complete && (w == nw - 1);
      odd  = last && (f.size() % 2 == 1);
      lo   = odd ? 8'($urandom) : f[2*w+1];
      drive_word({f[2*w], lo}, w == 0, last, last ? odd : 1'($urandom));
    end
  endtask

  task automatic send_frame(input bytes_t f, input bit chk_crc);
    send_words(f, (f.size() + 1) / 2, 1'b1, chk_crc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_crc"}, o_crc, 32'hFFFFFFFF);
    check({tag, "_ok"}, 32'(o_crc_ok), 32'd0);
    check({tag, "_crc_err"}, 32'(o_crc_err), 32'd0);
    check({tag, "_len_err"}, 32'(o_len_err), 32'd0);
    check({tag, "_len"}, 32'(o_frame_len), 32'd0);
    check({tag, "_err_cnt"}, 32'(o_err_cnt), 32'd0);
    check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
  endtask

  // Monitor: each o_done pulse consumes exactly one prediction.
  always @(negedge i_clk) begin
    if (o_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(o_done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("crc_ok", 32'(o_crc_ok), 32'(e.ok));
        check("crc_err", 32'(o_crc_err), 32'(!e.ok));
        check("len_err", 32'(o_len_err), 32'(e.len_err));
        check("frame_len", 32'(o_frame_len), 32'(e.len));
        check("frame_cnt", 32'(o_frame_cnt), 32'(e.frame_cnt));
        check("err_cnt", 32'(o_err_cnt), 32'(e.err_cnt));
        if (e.chk_crc) check("crc_reg", o_crc, e.crc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bytes_t fa, fb, fc;
    int     gap_next;
    int     plen;
    bit     bad;

    // Reset held three cycles under random inputs.
    i_rst = 1'b1;
    repeat (3) begin
      i_valid = 1'($urandom);
      i_sof   = 1'($urandom);
      i_eof   = 1'($urandom);
      i_odd   = 1'($urandom);
      i_data  = 16'($urandom);
      @(posedge i_clk);
      @(negedge i_clk);
      check("rst_hold_done", 32'(o_done), 32'd0);
    end
    check_reset_outputs("rst");
    i_rst   = 1'b0;
    i_valid = 1'b0;
    gap(2);

    // Good minimum-size frame, then the same frame with bit 3 of byte 20 flipped.
    fa = make_frame(60);
    send_frame(fa, 1'b1);
    gap(3);
    fb = fa;
    fb[20] = fb[20] ^ 8'h08;
    send_frame(fb, 1'b1);
    gap(3);

    // Odd-length frame ending in a half word.
    send_frame(make_frame(61), 1'b1);
    gap(3);

    // Frame A abandoned by a SOF at word 10; frame B starts on that word.
    fa = make_frame(60);
    send_words(fa, 10, 1'b0, 1'b0);
    send_frame(make_frame(60), 1'b1);
    gap(3);

    // Single word carrying both SOF and EOF.
    fc.delete();
    fc.push_back(8'($urandom));
    fc.push_back(8'($urandom));
    send_frame(fc, 1'b1);
    gap(3);

    // Reset pulsed while word 5 of a frame is presented.
    fa = make_frame(60);
    send_words(fa, 5, 1'b0, 1'b0);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    i_eof   = 1'b0;
    i_data  = {fa[10], fa[11]};
    @(posedge i_clk);
    m_frames = 0;
    m_errs   = 0;
    @(negedge i_clk);
    check_reset_outputs("midrst");
    i_rst   = 1'b0;
    i_valid = 1'b0;
    gap(2);
    send_frame(make_frame(60), 1'b1);
    gap(3);

    // Back-to-back: second SOF lands in the DONE cycle of the first frame.
    send_frame(make_frame(62), 1'b0);
    send_frame(make_frame(60), 1'b1);
    gap(3);

    // Length boundaries around the legal range.
    send_frame(make_frame(59), 1'b1);
    gap(2);
    send_frame(make_frame(1518), 1'b1);
    gap(2);
    send_frame(make_frame(1519), 1'b1);
    gap(2);

    // Random frames: lengths, corruption, and gaps (zero gap means back-to-back).
    gap_next = $urandom_range(0, 3);
    for (int k = 0; k < 40; k++) begin
      int g;
      plen = $urandom_range(0, 90);
      bad  = ($urandom_range(0, 3) == 0);
      fa   = make_frame(plen);
      if (bad) begin
        int bi;
        bi = $urandom_range(0, fa.size() - 1);
        fa[bi] = fa[bi] ^ (8'h01 << $urandom_range(0, 7));
      end
      g        = gap_next;
      gap_next = $urandom_range(0, 3);
      send_frame(fa, g != 0);
      gap(g);
    end

    begin
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 20) begin
        @(posedge i_clk);
        budget++;
      end
      @(negedge i_clk);
      check("pending_done", 32'(sb.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
